// File: rtl/sseg_display_arbiter_if.sv
// Purpose: bundles the requester-facing request/frame bus and the display drive outputs of the arbiter.
// Latency: none; wiring only.
// Backpressure: none; requests are level-sensitive and ownership is reported on gnt.
interface sseg_display_arbiter_if;
    logic [1:0]  req;
    logic [31:0] frame0;
    logic [31:0] frame1;
    logic [1:0]  gnt;
    logic [3:0]  an;
    logic [7:0]  seg;

    // Requesters / bench side: drive requests and frames, observe grant and display.
    modport master (
        output req, frame0, frame1,
        input  gnt, an, seg
    );

    // Arbiter side.
    modport slave (
        input  req, frame0, frame1,
        output gnt, an, seg
    );
endinterface

// File: rtl/sseg_display_arbiter.sv
// Purpose: round-robin owner of a 4-digit common-anode 7-seg display with minimum hold, blanking gap and digit muxing.
// Latency: req registered, then state/gnt one edge later; an/seg follow the state register by one more edge.
// Backpressure: none; a requester simply waits with req high until gnt shows its bit.
module sseg_display_arbiter #(
    parameter logic [16:0] REFRESH_DIV  = 17'd50_000,
    parameter logic [26:0] MIN_HOLD     = 27'd100_000_000,
    parameter logic [15:0] BLANK_CYCLES = 16'd50_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sseg_display_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN0  = 2'd1,
        S_OWN1  = 2'd2,
        S_BLANK = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    state_t      w_pick_state;
    logic [1:0]  r_req;
    logic        r_last;
    logic [26:0] r_hold;
    logic [15:0] r_blank;
    logic [16:0] r_refresh;
    logic [1:0]  r_digit;
    logic [1:0]  r_gnt;
    logic [3:0]  r_an;
    logic [7:0]  r_seg;

    logic        w_hold_done;
    logic        w_blank_done;
    logic        w_enter_own;
    logic [31:0] w_frame;
    logic [1:0]  w_gnt_nxt;
    logic [3:0]  w_an_nxt;
    logic [7:0]  w_seg_nxt;

    assign w_hold_done  = (r_hold >= (MIN_HOLD - 27'd1));
    assign w_blank_done = (r_blank >= (BLANK_CYCLES - 16'd1));
    assign w_enter_own  = ((w_state_nxt == S_OWN0) || (w_state_nxt == S_OWN1)) && (w_state_nxt != r_state);

    // Priority rule: favour whoever did not own last, else the previous owner, else stay idle.
    always_comb begin
        w_pick_state = S_IDLE;
        if (r_last) begin
            if (r_req[0])      w_pick_state = S_OWN0;
            else if (r_req[1]) w_pick_state = S_OWN1;
        end else begin
            if (r_req[1])      w_pick_state = S_OWN1;
            else if (r_req[0]) w_pick_state = S_OWN0;
        end
    end

    // Next-state logic: release or preempt into BLANK, re-arbitrate only when the gap ends.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = w_pick_state;
            S_OWN0:  if (!r_req[0] || (w_hold_done && r_req[1])) w_state_nxt = S_BLANK;
            S_OWN1:  if (!r_req[1] || (w_hold_done && r_req[0])) w_state_nxt = S_BLANK;
            S_BLANK: if (w_blank_done) w_state_nxt = w_pick_state;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register plus the registered copy of the request lines the FSM decides on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_req   <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= bus.req;
        end
    end

    // Ownership bookkeeping: last owner, saturating hold counter, blanking counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last  <= 1'b1;
            r_hold  <= 27'd0;
            r_blank <= 16'd0;
        end else begin
            if (w_enter_own) begin
                r_last <= (w_state_nxt == S_OWN1);
                r_hold <= 27'd0;
            end else if (((r_state == S_OWN0) || (r_state == S_OWN1)) && (r_hold != '1)) begin
                r_hold <= r_hold + 27'd1;
            end

            if ((w_state_nxt == S_BLANK) && (r_state != S_BLANK)) begin
                r_blank <= 16'd0;
            end else if ((r_state == S_BLANK) && !w_blank_done) begin
                r_blank <= r_blank + 16'd1;
            end
        end
    end

    // Free-running digit scan, independent of who owns the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh <= 17'd0;
            r_digit   <= 2'd0;
        end else if (r_refresh >= (REFRESH_DIV - 17'd1)) begin
            r_refresh <= 17'd0;
            r_digit   <= r_digit + 2'd1;
        end else begin
            r_refresh <= r_refresh + 17'd1;
        end
    end

    // Output decode: grant tracks the incoming state, anode/segment drive tracks the current owner.
    always_comb begin
        w_gnt_nxt = 2'b00;
        w_an_nxt  = 4'b1111;
        w_seg_nxt = 8'hFF;
        w_frame   = (r_state == S_OWN1) ? bus.frame1 : bus.frame0;
        if (w_state_nxt == S_OWN0) w_gnt_nxt = 2'b01;
        if (w_state_nxt == S_OWN1) w_gnt_nxt = 2'b10;
        if ((r_state == S_OWN0) || (r_state == S_OWN1)) begin
            w_an_nxt  = ~(4'b0001 << r_digit);
            w_seg_nxt = w_frame[{r_digit, 3'b000} +: 8];
        end
    end

    // Registered display and grant outputs; reset forces them dark/ungranted immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt <= 2'b00;
            r_an  <= 4'b1111;
            r_seg <= 8'hFF;
        end else begin
            r_gnt <= w_gnt_nxt;
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
        end
    end

    assign bus.gnt = r_gnt;
    assign bus.an  = r_an;
    assign bus.seg = r_seg;

endmodule

// File: doc/sseg_display_arbiter.md
# sseg_display_arbiter

Shares the board's four-digit, common-anode seven-segment display between two pattern generators, for example the rotating-square engine and a hex readout. Each requester raises `req` and presents a 32-bit frame of four segment bytes. The arbiter grants ownership round-robin and enforces a minimum hold time before preemption. Between owners it inserts a blanking gap, and it performs the digit multiplexing itself.

## Interface
- `REFRESH_DIV`, default 17'd50_000: clock cycles per digit slot (~500 Hz per digit at 100 MHz); must be ≥1.
- `MIN_HOLD`, default 27'd100_000_000: cycles an owner keeps the display before a waiting requester may preempt it; must be ≥1.
- `BLANK_CYCLES`, default 16'd50_000: length of the all-off gap between owners; must be ≥1.
- `clk`  in  1  system clock (100 MHz); single clock domain.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req`  in  2  `req[i]` high means requester i wants the display; level-sensitive.
- `frame0`  in  32  requester 0 segment bytes. Digit k is at `[8k+7:8k]`; digit 0 is rightmost. Each byte is active-low, ordered {dp,g,f,e,d,c,b,a}.
- `frame1`  in  32  requester 1 segment bytes, same layout as `frame0`.
- `gnt`  out  2  one-hot or zero ownership grant; registered.
- `an`  out  4  digit anodes, active-low; registered.
- `seg`  out  8  segment drive, active-low {dp,g,f,e,d,c,b,a}; registered.

## Operation
- **FSM states:** IDLE, OWN0, OWN1, BLANK. Reset state is IDLE.
- **IDLE:**
  - If `req`≠0, go to OWNi per the priority rule.
  - Otherwise stay in IDLE.
- **Priority rule:** a `last` register (reset 1) records the most recent owner.
  - Grant the requester ≠`last` if it is requesting.
  - Otherwise grant `last` if it is requesting.
  - After reset with both requesting, requester 0 wins.
- **OWNi:**
  - `gnt` = one-hot i.
  - On entry, load `last` = i and clear the hold counter.
  - The hold counter increments each cycle and saturates; `hold_done` = count ≥ `MIN_HOLD`-1.
  - Go to BLANK if `req[i]`=0 (release).
  - Also go to BLANK if `hold_done` and `req[1-i]`=1 (preempt).
  - Otherwise stay in OWNi.
- **BLANK:**
  - `gnt`=0; the blank counter runs for exactly `BLANK_CYCLES` cycles.
  - At the end, apply the priority rule to current `req`, or go to IDLE if `req`=0.
  - `req` changes during BLANK are ignored until the end of BLANK.
- **Display multiplexing:**
  - The refresh counter and the 2-bit `digit_select` run from reset regardless of FSM state.
  - `digit_select` increments (wrapping 3→0) when the refresh counter reaches `REFRESH_DIV`-1; the counter then clears.
- **Output mapping:**
  - In OWNi: `an` = 4'b1110, 1101, 1011, 0111 for `digit_select` 0..3. `seg` = frame i byte [8·`digit_select`+7 : 8·`digit_select`], sampled live, not latched.
  - In IDLE and BLANK: `an`=4'b1111 and `seg`=8'hFF.
- **Counter widths:** refresh counter 17 bits, hold counter 27 bits, blank counter 16 bits. Comparisons use full parameter width; counters never wrap.

## Timing
- **Reset values:** `gnt`=2'b00, `an`=4'b1111, `seg`=8'hFF. FSM is in IDLE, all counters are 0, `digit_select`=0, `last`=1.
- **Grant latency:** `req` sampled high in IDLE at edge t gives `gnt` high after edge t+1. Outputs reflect the owner's frame after edge t+2.
- **Release latency:** owner drops `req` at edge t; `gnt`=0 and state is BLANK after edge t+1; `an`=4'b1111 after edge t+2.
- **Next grant:** `gnt` to the next owner appears exactly `BLANK_CYCLES` cycles after `gnt` fell.
- **Preemption:** occurs no earlier than `MIN_HOLD` cycles after `gnt` rose. With the other request already pending, `gnt` falls on the cycle after `hold_done` first asserts.
- **Simultaneous release and preempt:** the owner drops `req` in the same cycle as `hold_done` while the other is requesting. The result is one BLANK, then a grant to the other.
- **Frame changes:** a change on the owner's frame appears on `seg` one cycle after sampling. A change on a non-owner's frame has no effect.
- **Mid-operation reset:** asserting `rst_n` low forces all outputs to their reset values immediately, without waiting for a clock edge. Normal operation resumes on the first edge after release.
- **Exclusivity:** `gnt` is never 2'b11 in any cycle.

## Test plan
All scenarios use `REFRESH_DIV`=4, `MIN_HOLD`=20, `BLANK_CYCLES`=3.

1. **Reset, then both request.** Hold reset, then raise `req`=2'b11. Required: `gnt`=2'b01 two edges after reset release. `an` steps through 1110→1101→1011→0111 every 4 cycles. `seg` matches the `frame0` bytes.
2. **Release and blanking.** Requester 0 owns, then drops `req[0]`, with `req[1]`=0. Required: `gnt`=00 next cycle; `an`=1111 and `seg`=FF thereafter; FSM returns to IDLE after 3 cycles.
3. **Preemption timing.** Requester 0 owns with `req[1]` raised at grant+2. Required: `gnt[0]` falls exactly 20 cycles after it rose. `gnt`=2'b10 follows 3 cycles later, and `seg` shows `frame1`.
4. **Round-robin fairness.** Both requesters hold `req` continuously for 200 cycles. Required: `gnt` alternates 01,10,01… with 20-cycle ownerships separated by 3-cycle gaps; `gnt` is never 11.
5. **Mid-operation reset.** Pulse `rst_n` low mid-digit while requester 1 owns. Required: `an`=1111, `seg`=FF and `gnt`=00 asynchronously. After release with `req`=11, requester 0 is granted first.
6. **Live frame update.** Change `frame0[15:8]` from 8'hB0 to 8'h9C while digit 1 is active. Required: `seg`=8'h9C one cycle later; toggling `frame1` during the same window leaves `seg` unchanged.
